// File: rtl/axis_byte_packer_pkg.sv
// Shared types and sizing helpers for the AXIS byte packer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package axis_byte_packer_pkg;

  typedef logic [7:0] byte_t;

  // Default build matches a 24-bit processor input word.
  localparam int unsigned DEFAULT_WORD_WIDTH = 24;
  localparam int unsigned WORD_BYTES         = DEFAULT_WORD_WIDTH / 8;

  function automatic int unsigned word_bytes(input int unsigned word_width);
    return word_width / 8;
  endfunction

  // Byte counter width; never narrower than one bit so WORD_BYTES==1 still builds.
  function automatic int unsigned cnt_width(input int unsigned n_bytes);
    return (n_bytes <= 2) ? 1 : $clog2(n_bytes);
  endfunction

  localparam int unsigned CNT_WIDTH = cnt_width(WORD_BYTES);

endpackage

// File: rtl/axis_byte_packer_idle_timer.sv
// Idle counter: counts enabled cycles, pulses expire on the cycle it would reach LIMIT.
// Latency: expire is combinational from the count and en; the count clears on the next edge.
// Backpressure: none; en/clr are qualified by the parent. LIMIT==0 disables (expire tied 0).
// Ports: clk, arstn, en (count this cycle), clr (synchronous clear), expire (pulse).
module axis_byte_packer_idle_timer #(
  parameter int unsigned LIMIT = 1024
) (
  input  logic clk,
  input  logic arstn,
  input  logic en,
  input  logic clr,
  output logic expire
);

  if (LIMIT == 0) begin : g_off
    logic unused_inputs;
    assign unused_inputs = &{1'b0, clk, arstn, en, clr};
    assign expire = 1'b0;
  end else begin : g_on
    localparam int unsigned TW = $clog2(LIMIT + 1);

    logic [TW-1:0] tmr_q;
    logic [TW-1:0] tmr_d;
    logic          hit;

    // Expire on the increment that would land on LIMIT, so the counter never
    // holds LIMIT and can never wrap.
    assign hit    = en && (tmr_q == TW'(LIMIT - 1));
    assign expire = hit;

    always_comb begin
      tmr_d = tmr_q;
      if (clr || hit) begin
        tmr_d = '0;
      end else if (en) begin
        tmr_d = tmr_q + 1'b1;
      end
    end

    always_ff @(posedge clk or negedge arstn) begin
      if (!arstn) begin
        tmr_q <= '0;
      end else begin
        tmr_q <= tmr_d;
      end
    end
  end

endmodule

// File: rtl/axis_byte_packer.sv
// Packs WORD_BYTES consecutive 8-bit AXIS bytes (big-endian) into one WORD_WIDTH-bit beat.
// Latency: word valid one cycle after its final byte is accepted; 1 byte/cycle sustained.
// Backpressure: only the final byte of a word waits for a free/handing-off output register.
// Ports: clk, arstn; s_axis_* byte input; m_axis_* word output; drop = partial word discarded.
module axis_byte_packer
  import axis_byte_packer_pkg::*;
#(
  parameter int unsigned WORD_WIDTH   = 24,
  parameter int unsigned IDLE_TIMEOUT = 1024
) (
  input  logic                  clk,
  input  logic                  arstn,
  input  byte_t                 s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [WORD_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  drop
);

  localparam int unsigned NB = word_bytes(WORD_WIDTH);
  localparam int unsigned CW = cnt_width(NB);

  if ((WORD_WIDTH % 8) != 0 || WORD_WIDTH < 8) begin : g_bad_width
    $error("axis_byte_packer: WORD_WIDTH must be a non-zero multiple of 8");
  end

  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  m_vld_q, m_vld_d;
  logic [WORD_WIDTH-1:0] m_dat_q, m_dat_d;
  logic                  drop_q, drop_d;

  logic                  is_last;
  logic                  accept;
  logic                  expire;
  logic                  tmr_en;
  logic                  tmr_clr;
  logic [WORD_WIDTH-1:0] word_full;

  assign is_last       = (cnt_q == CW'(NB - 1));
  // Non-final bytes never wait; the final byte needs the output register free
  // now or handing off in this same cycle.
  assign s_axis_tready = !is_last || !m_vld_q || m_axis_tready;
  assign accept        = s_axis_tvalid && s_axis_tready;

  if (NB == 1) begin : g_no_shift
    assign word_full = s_axis_tdata;
  end else begin : g_shift
    localparam int unsigned SW = WORD_WIDTH - 8;
    logic [SW-1:0] sh_q, sh_d;

    always_comb begin
      sh_d = sh_q;
      if (accept && !is_last) begin
        sh_d = (sh_q << 8) | SW'(s_axis_tdata);
      end
    end

    always_ff @(posedge clk or negedge arstn) begin
      if (!arstn) begin
        sh_q <= '0;
      end else begin
        sh_q <= sh_d;
      end
    end

    assign word_full = {sh_q, s_axis_tdata};
  end

  // Only a starved partial word ages; a downstream stall holds the count.
  assign tmr_en  = (cnt_q != '0) && !s_axis_tvalid && s_axis_tready;
  assign tmr_clr = accept || (cnt_q == '0);

  axis_byte_packer_idle_timer #(
    .LIMIT (IDLE_TIMEOUT)
  ) u_idle_timer (
    .clk    (clk),
    .arstn  (arstn),
    .en     (tmr_en),
    .clr    (tmr_clr),
    .expire (expire)
  );

  always_comb begin
    cnt_d   = cnt_q;
    m_vld_d = m_vld_q;
    m_dat_d = m_dat_q;
    drop_d  = 1'b0;

    if (m_vld_q && m_axis_tready) begin
      m_vld_d = 1'b0;
    end

    if (accept) begin
      if (is_last) begin
        // Overrides the handoff clear above: back-to-back words, no bubble.
        m_dat_d = word_full;
        m_vld_d = 1'b1;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (expire) begin
      // Stale shift contents are harmless: a new word overwrites every slot.
      cnt_d  = '0;
      drop_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      cnt_q   <= '0;
      m_vld_q <= 1'b0;
      m_dat_q <= '0;
      drop_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      m_vld_q <= m_vld_d;
      m_dat_q <= m_dat_d;
      drop_q  <= drop_d;
    end
  end

  assign m_axis_tvalid = m_vld_q;
  assign m_axis_tdata  = m_dat_q;
  assign drop          = drop_q;

endmodule

// File: tb/tb_axis_byte_packer.sv
module tb_axis_byte_packer;

  localparam int WW = 24;
  localparam int WB = WW / 8;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          arstn;
  logic [7:0]    s_tdata;
  logic          s_tvalid;
  logic          s_tready;
  logic [WW-1:0] m_tdata;
  logic          m_tvalid;
  logic          m_tready;
  logic          drop;

  always #5 clk = ~clk;

  axis_byte_packer #(
    .WORD_WIDTH   (WW),
    .IDLE_TIMEOUT (TO)
  ) dut (
    .clk           (clk),
    .arstn         (arstn),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .drop          (drop)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: bytes collected so far, words owed downstream, output occupancy.
  logic [WW-1:0] exp_q[$];
  logic [7:0]    part[$];
  bit            out_full;
  int            idle;
  bit            exp_drop;
  bit            acc_now;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    part.delete();
    exp_q.delete();
    out_full = 0;
    idle     = 0;
    exp_drop = 0;
    acc_now  = 0;
  endtask

  task automatic model_step();
    bit            exp_rdy;
    logic [WW-1:0] w;
    exp_rdy = (part.size() != WB - 1) || !out_full || m_tready;
    chk("s_tready", {31'd0, s_tready}, {31'd0, exp_rdy});
    chk("m_tvalid", {31'd0, m_tvalid}, {31'd0, out_full});
    chk("drop", {31'd0, drop}, {31'd0, exp_drop});
    exp_drop = 0;
    acc_now  = s_tvalid && exp_rdy;
    if (out_full && m_tready) out_full = 0;
    if (acc_now) begin
      part.push_back(s_tdata);
      idle = 0;
      if (part.size() == WB) begin
        w = '0;
        foreach (part[i]) w = (w << 8) | WW'(part[i]);
        exp_q.push_back(w);
        part.delete();
        out_full = 1;
      end
    end else if (part.size() == 0) begin
      idle = 0;
    end else if (!s_tvalid && exp_rdy) begin
      idle++;
      if (idle == TO) begin
        part.delete();
        idle     = 0;
        exp_drop = 1;
      end
    end
  endtask

  task automatic step(input bit v, input logic [7:0] d, input bit r);
    @(negedge clk);
    s_tvalid = v;
    s_tdata  = d;
    m_tready = r;
    #1;
    model_step();
  endtask

  task automatic send_byte(input logic [7:0] d, input bit r);
    int k;
    k = 0;
    do begin
      step(1'b1, d, r);
      k++;
    end while (!acc_now && k < 50);
    if (!acc_now) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: byte %0h not accepted within %0d cycles", d, k);
    end
  endtask

  task automatic idle_cycles(input int n, input bit r);
    repeat (n) step(1'b0, 8'($urandom), r);
  endtask

  // Monitor: every presented beat must match the oldest owed word; pop on handshake.
  always @(negedge clk) begin
    #2;
    if (arstn && m_tvalid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_beat: got %0h expected no beat at %0t", m_tdata, $time);
      end else begin
        chk("tdata", {8'd0, m_tdata}, {8'd0, exp_q[0]});
        if (m_tready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    bit         v;
    bit         pend;
    logic [7:0] d;

    arstn    = 1'b0;
    s_tvalid = 1'b0;
    s_tdata  = 8'h00;
    m_tready = 1'b0;
    model_reset();
    #12;
    chk("rst_m_tvalid", {31'd0, m_tvalid}, 32'd0);
    chk("rst_m_tdata", {8'd0, m_tdata}, 32'd0);
    chk("rst_drop", {31'd0, drop}, 32'd0);
    chk("rst_s_tready", {31'd0, s_tready}, 32'd1);
    @(negedge clk);
    arstn = 1'b1;

    // Order and one-cycle latency.
    send_byte(8'hA1, 1'b1);
    send_byte(8'hB2, 1'b1);
    send_byte(8'hC3, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    chk("order_latency", {8'd0, m_tdata}, 32'h00A1B2C3);
    idle_cycles(2, 1'b1);

    // Back-to-back stream: no ready drop, no gap between beats.
    for (int i = 1; i <= 6; i++) send_byte(8'(i), 1'b1);
    idle_cycles(3, 1'b1);

    // Backpressure: final byte waits, held word stable, release with no bubble.
    send_byte(8'h55, 1'b0);
    send_byte(8'h66, 1'b0);
    send_byte(8'h77, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    step(1'b1, 8'h33, 1'b0);
    step(1'b1, 8'h33, 1'b0);
    chk("bp_held_word", {8'd0, m_tdata}, 32'h00556677);
    send_byte(8'h33, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    chk("bp_second_word", {8'd0, m_tdata}, 32'h00112233);
    idle_cycles(2, 1'b1);

    // Timeout: partial word discarded, next word clean.
    send_byte(8'hAA, 1'b1);
    send_byte(8'hBB, 1'b1);
    idle_cycles(TO + 2, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h03, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    chk("timeout_clean_word", {8'd0, m_tdata}, 32'h00010203);
    idle_cycles(2, 1'b1);

    // Expiry race: byte arrives on the cycle the timer would expire.
    send_byte(8'h5A, 1'b1);
    idle_cycles(TO - 1, 1'b1);
    send_byte(8'h5B, 1'b1);
    idle_cycles(TO - 1, 1'b1);
    send_byte(8'h5C, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    chk("race_word", {8'd0, m_tdata}, 32'h005A5B5C);
    idle_cycles(2, 1'b1);

    // Asynchronous reset with a held word and a partial word.
    send_byte(8'h31, 1'b0);
    send_byte(8'h32, 1'b0);
    send_byte(8'h33, 1'b0);
    send_byte(8'h41, 1'b0);
    send_byte(8'h42, 1'b0);
    @(negedge clk);
    s_tvalid = 1'b0;
    #3;
    arstn = 1'b0;
    #1;
    chk("arst_m_tvalid", {31'd0, m_tvalid}, 32'd0);
    chk("arst_s_tready", {31'd0, s_tready}, 32'd1);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    arstn = 1'b1;
    send_byte(8'h61, 1'b1);
    send_byte(8'h62, 1'b1);
    send_byte(8'h63, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    chk("post_reset_word", {8'd0, m_tdata}, 32'h00616263);
    idle_cycles(2, 1'b1);

    // Randomized traffic with random stalls and occasional long gaps.
    pend = 0;
    v    = 0;
    d    = 8'h00;
    for (int c = 0; c < 3000; c++) begin
      if (!pend) begin
        if ($urandom_range(0, 99) < 3) begin
          repeat ($urandom_range(10, 20)) step(1'b0, 8'h00, 1'($urandom_range(0, 1)));
        end
        v = ($urandom_range(0, 99) < 70);
        d = 8'($urandom);
      end
      step(v, d, ($urandom_range(0, 99) < 65));
      pend = v && !acc_now;
    end
    idle_cycles(5, 1'b1);
    chk("all_words_delivered", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
